rvm_shift_arb: RTL and testbench

RVM_SHIFT_ARB -- requirements
Module: rvm_shift_arb

---
 rtl/rvm_shift_arb_if.sv | 56 +++++
 rtl/rvm_shift_arb.sv | 113 +++++++++++
 tb/tb_rvm_shift_arb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvm_shift_arb_if.sv
// rvm_shift_arb_if -- bundle of every handshake/data signal around the
// shift arbiter: two requester request channels, two response channels and
// the link to the shared shifter.
//
//   req0/1_valid, req0/1_op[1:0], req0/1_lhs[31:0], req0/1_rhs[4:0] : request in
//   req0/1_ready                                                     : request accepted
//   rsp0/1_valid, rsp0/1_result[31:0]                                : response out
//   rsp0/1_ready                                                     : response taken
//   sh_op[1:0], sh_lhs[31:0], sh_rhs[4:0]                            : to shifter
//   sh_valid, sh_result[31:0]                                        : from shifter
//
// Modport "slave" is the arbiter's view; "master" is the view of the
// environment (requesters plus shifter).
interface rvm_shift_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_lhs;
  logic [4:0]  req0_rhs;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_lhs;
  logic [4:0]  req1_rhs;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;

  logic [1:0]  sh_op;
  logic [31:0] sh_lhs;
  logic [4:0]  sh_rhs;
  logic        sh_valid;
  logic [31:0] sh_result;

  modport slave (
    input  req0_valid, req0_op, req0_lhs, req0_rhs, rsp0_ready,
    input  req1_valid, req1_op, req1_lhs, req1_rhs, rsp1_ready,
    input  sh_valid, sh_result,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result,
    output sh_op, sh_lhs, sh_rhs
  );

  modport master (
    output req0_valid, req0_op, req0_lhs, req0_rhs, rsp0_ready,
    output req1_valid, req1_op, req1_lhs, req1_rhs, rsp1_ready,
    output sh_valid, sh_result,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result,
    input  sh_op, sh_lhs, sh_rhs
  );
endinterface

// File: rtl/rvm_shift_arb.sv
// rvm_shift_arb -- arbitrates two requesters onto one shared shifter, with
// exactly one transaction in flight (IDLE -> ISSUE -> RESP -> IDLE).
//
//   g_clk    : single clock, rising edge
//   g_resetn : asynchronous active-low reset
//   bus      : rvm_shift_arb_if.slave (request/response channels of both
//              requesters and the shared-shifter link)
//
// A grant is made in IDLE (reqN_ready high combinationally for the winner
// only), operands are presented to the shifter for exactly the ISSUE cycle,
// and the result is held in RESP until the granted requester takes it. When
// both requesters are valid the priority pointer decides; it flips to the
// non-granted requester at every completed response, so contention
// alternates.
module rvm_shift_arb (
  input  logic           g_clk,
  input  logic           g_resetn,
  rvm_shift_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;

  state_t      state;
  logic        prio;
  logic        grant_id;
  logic [1:0]  op_q;
  logic [31:0] lhs_q;
  logic [4:0]  rhs_q;
  logic [31:0] result_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;

  logic pick0;
  logic pick1;
  logic take;

  // pick0/pick1 are mutually exclusive: with both valid, prio breaks the tie.
  always_comb begin
    pick0 = bus.req0_valid && (!bus.req1_valid || !prio);
    pick1 = bus.req1_valid && (!bus.req0_valid ||  prio);
    take  = grant_id ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Ready is gated by g_resetn so no request can appear accepted while the
  // block is held in reset.
  assign bus.req0_ready = g_resetn && (state == IDLE) && pick0;
  assign bus.req1_ready = g_resetn && (state == IDLE) && pick1;

  // Operand isolation: the shifter only sees operands during ISSUE.
  assign bus.sh_op  = (state == ISSUE) ? op_q  : 2'b00;
  assign bus.sh_lhs = (state == ISSUE) ? lhs_q : 32'h0;
  assign bus.sh_rhs = (state == ISSUE) ? rhs_q : 5'h0;

  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_result = rsp0_valid_q ? result_q : 32'h0;
  assign bus.rsp1_result = rsp1_valid_q ? result_q : 32'h0;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state        <= IDLE;
      prio         <= 1'b0;
      grant_id     <= 1'b0;
      op_q         <= 2'b00;
      lhs_q        <= 32'h0;
      rhs_q        <= 5'h0;
      result_q     <= 32'h0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick0 || pick1) begin
            grant_id <= pick1;
            op_q     <= pick1 ? bus.req1_op  : bus.req0_op;
            lhs_q    <= pick1 ? bus.req1_lhs : bus.req0_lhs;
            rhs_q    <= pick1 ? bus.req1_rhs : bus.req0_rhs;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          // A NOP always completes with zero, whatever the shifter reports.
          result_q     <= (bus.sh_valid && (op_q != OP_NOP)) ? bus.sh_result : 32'h0;
          rsp0_valid_q <= !grant_id;
          rsp1_valid_q <=  grant_id;
          state        <= RESP;
        end

        RESP: begin
          if (take) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            result_q     <= 32'h0;
            prio         <= !grant_id;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvm_shift_arb.sv
// tb_rvm_shift_arb -- directed self-checking bench for rvm_shift_arb.
// The bench plays both requesters and the shared shifter; every expected
// value below is a hand-computed constant.
module tb_rvm_shift_arb;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  logic g_clk;
  logic g_resetn;
  logic sh_kill;
  int   checks;
  int   errors;

  rvm_shift_arb_if bus ();

  rvm_shift_arb dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus.slave)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  // Shared shifter: combinational, reports valid for any real shift op.
  always_comb begin
    bus.sh_valid  = !sh_kill && (bus.sh_op != OP_NOP);
    bus.sh_result = 32'h0;
    case (bus.sh_op)
      OP_SLL:  bus.sh_result = bus.sh_lhs << bus.sh_rhs;
      OP_SRL:  bus.sh_result = bus.sh_lhs >> bus.sh_rhs;
      OP_SRA:  bus.sh_result = $unsigned($signed(bus.sh_lhs) >>> bus.sh_rhs);
      default: bus.sh_result = 32'h0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic v0, input logic [1:0] op0, input logic [31:0] lhs0, input logic [4:0] rhs0,
    input logic v1, input logic [1:0] op1, input logic [31:0] lhs1, input logic [4:0] rhs1);
    bus.req0_valid = v0;
    bus.req0_op    = op0;
    bus.req0_lhs   = lhs0;
    bus.req0_rhs   = rhs0;
    bus.req1_valid = v1;
    bus.req1_op    = op1;
    bus.req1_lhs   = lhs1;
    bus.req1_rhs   = rhs1;
  endtask

  task automatic tick;
    @(posedge g_clk);
    #2;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    sh_kill     = 1'b0;
    g_resetn    = 1'b0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    applyStimulus(1'b1, OP_SLL, 32'h1, 5'd4, 1'b1, OP_SRL, 32'h1, 5'd1);
    #3;

    // Reset state: everything low even with requests pending.
    checkOutput("rst_req0_ready", bus.req0_ready, 0);
    checkOutput("rst_req1_ready", bus.req1_ready, 0);
    checkOutput("rst_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("rst_sh_op", bus.sh_op, 0);
    checkOutput("rst_sh_lhs", bus.sh_lhs, 0);
    checkOutput("rst_rsp0_result", bus.rsp0_result, 0);
    tick;
    tick;

    // Single SLL from requester 0: ready, ISSUE, RESP, done.
    g_resetn = 1'b1;
    applyStimulus(1'b1, OP_SLL, 32'h1, 5'd4, 1'b0, OP_NOP, 32'h0, 5'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    checkOutput("sll_req0_ready", bus.req0_ready, 1);
    checkOutput("sll_req1_ready", bus.req1_ready, 0);
    checkOutput("sll_idle_sh_op", bus.sh_op, 0);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    #1;
    checkOutput("sll_issue_ready0", bus.req0_ready, 0);
    checkOutput("sll_issue_sh_op", bus.sh_op, 32'h1);
    checkOutput("sll_issue_sh_lhs", bus.sh_lhs, 32'h1);
    checkOutput("sll_issue_sh_rhs", bus.sh_rhs, 32'h4);
    checkOutput("sll_issue_rsp0_valid", bus.rsp0_valid, 0);
    tick;
    #1;
    checkOutput("sll_resp_valid", bus.rsp0_valid, 1);
    checkOutput("sll_resp_result", bus.rsp0_result, 32'h0000_0010);
    checkOutput("sll_resp_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("sll_resp_sh_op", bus.sh_op, 0);
    tick;
    #1;
    checkOutput("sll_done_valid", bus.rsp0_valid, 0);
    checkOutput("sll_done_result", bus.rsp0_result, 0);

    // Reset pulse restores prio=0; both requesters contend.
    g_resetn = 1'b0;
    #1;
    g_resetn = 1'b1;
    applyStimulus(1'b1, OP_SRA, 32'h8000_0000, 5'd31, 1'b1, OP_SRL, 32'h8000_0000, 5'd31);
    #1;
    checkOutput("both_req0_ready", bus.req0_ready, 1);
    checkOutput("both_req1_ready", bus.req1_ready, 0);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b1, OP_SRL, 32'h8000_0000, 5'd31);
    #1;
    checkOutput("both_issue_req1_ready", bus.req1_ready, 0);
    tick;
    #1;
    checkOutput("both_sra_valid", bus.rsp0_valid, 1);
    checkOutput("both_sra_result", bus.rsp0_result, 32'hFFFF_FFFF);
    checkOutput("both_resp_req1_ready", bus.req1_ready, 0);
    checkOutput("both_resp_rsp1_valid", bus.rsp1_valid, 0);
    tick;
    #1;
    checkOutput("both_idle_req1_ready", bus.req1_ready, 1);
    checkOutput("both_idle_rsp0_valid", bus.rsp0_valid, 0);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    tick;
    #1;
    checkOutput("both_srl_valid", bus.rsp1_valid, 1);
    checkOutput("both_srl_result", bus.rsp1_result, 32'h0000_0001);
    checkOutput("both_srl_rsp0_result", bus.rsp0_result, 0);
    tick;

    // Back-pressure on requester 1; rsp0_ready high must be ignored.
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b1, OP_SLL, 32'h3, 5'd1);
    bus.rsp1_ready = 1'b0;
    bus.rsp0_ready = 1'b1;
    #1;
    checkOutput("bp_req1_ready", bus.req1_ready, 1);
    tick;
    applyStimulus(1'b1, OP_SLL, 32'h7, 5'd7, 1'b1, OP_SLL, 32'h3, 5'd1);
    tick;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid_%0d", i), bus.rsp1_valid, 1);
      checkOutput($sformatf("bp_result_%0d", i), bus.rsp1_result, 32'h6);
      checkOutput($sformatf("bp_req0_ready_%0d", i), bus.req0_ready, 0);
      checkOutput($sformatf("bp_req1_ready_%0d", i), bus.req1_ready, 0);
      checkOutput($sformatf("bp_sh_op_%0d", i), bus.sh_op, 0);
      checkOutput($sformatf("bp_rsp0_valid_%0d", i), bus.rsp0_valid, 0);
      tick;
      #1;
    end
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    bus.rsp1_ready = 1'b1;
    tick;
    #1;
    checkOutput("bp_done_valid", bus.rsp1_valid, 0);

    // Continuous contention: grants alternate starting with requester 0.
    applyStimulus(1'b1, OP_SLL, 32'h5, 5'd1, 1'b1, OP_SRL, 32'h100, 5'd4);
    #1;
    for (int k = 0; k < 8; k++) begin
      logic exp_id;
      exp_id = k[0];
      checkOutput($sformatf("cont_ready0_%0d", k), bus.req0_ready, !exp_id);
      checkOutput($sformatf("cont_ready1_%0d", k), bus.req1_ready, exp_id);
      tick;
      #1;
      tick;
      #1;
      checkOutput($sformatf("cont_rsp0_valid_%0d", k), bus.rsp0_valid, !exp_id);
      checkOutput($sformatf("cont_rsp1_valid_%0d", k), bus.rsp1_valid, exp_id);
      checkOutput($sformatf("cont_result_%0d", k),
                  exp_id ? bus.rsp1_result : bus.rsp0_result,
                  exp_id ? 32'h0000_0010 : 32'h0000_000A);
      tick;
      #1;
    end
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);

    // NOP: operands visible only in ISSUE, result zero.
    applyStimulus(1'b1, OP_NOP, 32'hDEAD_BEEF, 5'd3, 1'b0, OP_NOP, 32'h0, 5'd0);
    #1;
    checkOutput("nop_ready", bus.req0_ready, 1);
    checkOutput("nop_idle_sh_lhs", bus.sh_lhs, 0);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    #1;
    checkOutput("nop_issue_sh_lhs", bus.sh_lhs, 32'hDEAD_BEEF);
    checkOutput("nop_issue_sh_op", bus.sh_op, 0);
    checkOutput("nop_issue_sh_rhs", bus.sh_rhs, 32'h3);
    tick;
    #1;
    checkOutput("nop_resp_valid", bus.rsp0_valid, 1);
    checkOutput("nop_resp_result", bus.rsp0_result, 0);
    checkOutput("nop_resp_sh_lhs", bus.sh_lhs, 0);
    tick;

    // prio now points at requester 1; a reset in RESP must restore prio=0.
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b1, OP_SRL, 32'hF0, 5'd4);
    bus.rsp1_ready = 1'b0;
    #1;
    checkOutput("rr_req1_ready", bus.req1_ready, 1);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    tick;
    #1;
    checkOutput("rr_resp_valid", bus.rsp1_valid, 1);
    checkOutput("rr_resp_result", bus.rsp1_result, 32'h0000_000F);
    g_resetn = 1'b0;
    #1;
    checkOutput("rr_async_valid", bus.rsp1_valid, 0);
    checkOutput("rr_async_result", bus.rsp1_result, 0);
    g_resetn = 1'b1;
    applyStimulus(1'b1, OP_SLL, 32'h1, 5'd1, 1'b1, OP_SLL, 32'h2, 5'd1);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    checkOutput("rr_grant0_ready0", bus.req0_ready, 1);
    checkOutput("rr_grant0_ready1", bus.req1_ready, 0);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    #1;
    checkOutput("rr_no_stale_rsp1", bus.rsp1_valid, 0);
    tick;
    #1;
    checkOutput("rr_rsp0_valid", bus.rsp0_valid, 1);
    checkOutput("rr_rsp0_result", bus.rsp0_result, 32'h2);
    tick;

    // Shifter not reporting valid in ISSUE yields a zero result.
    sh_kill = 1'b1;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b1, OP_SLL, 32'h9, 5'd1);
    #1;
    checkOutput("kill_ready1", bus.req1_ready, 1);
    tick;
    applyStimulus(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0, OP_NOP, 32'h0, 5'd0);
    tick;
    #1;
    checkOutput("kill_valid", bus.rsp1_valid, 1);
    checkOutput("kill_result", bus.rsp1_result, 0);
    tick;
    sh_kill = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
